// File: rtl/otter_uart_tx_if.sv
// Bus link between the core (initiator) and the UART transmitter (responder).
//
// Handshake: the initiator raises req with we/addr/wdata stable and holds them
// until it sees ack. The responder accepts on a rising clk edge where req=1 and
// ack=0, and pulses ack for exactly one cycle on the following cycle, with
// rdata valid only while ack=1 (0 otherwise). req still high while ack=1 is not
// a new request, so back-to-back accesses complete at most once every 2 cycles.
interface otter_uart_tx_if;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable bit period,
// sticky overflow flag and a level interrupt for "all data sent".
module otter_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RESET = 16'd868
) (
    input  logic                  clk,
    input  logic                  rst,
    otter_uart_tx_if.slave        bus,
    output logic                  tx,
    output logic                  irq,
    output logic [1:0]            fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t      state;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        busy;
    logic        accept;
    logic        push;
    logic        pop;
    logic        wr_status;
    logic        wr_baud;
    logic        overflow;
    logic        ie;
    logic [15:0] baud_div;
    logic [15:0] next_div;
    logic [15:0] eff_div;
    logic [15:0] bit_cnt;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign accept    = bus.req & ~bus.ack;
    assign push      = accept & bus.we & (bus.addr[3:2] == 2'd0);
    assign wr_status = accept & bus.we & (bus.addr[3:2] == 2'd1);
    assign wr_baud   = accept & bus.we & (bus.addr[3:2] == 2'd2);
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == DEPTH_CNT);
    assign empty     = (wr_ptr == rd_ptr);
    assign busy      = (state != IDLE);
    assign pop       = (state == IDLE) & ~empty;
    // Divisors below 2 cannot form a valid bit, so they are treated as 2.
    assign next_div  = (baud_div < 16'd2) ? 16'd2 : baud_div;
    assign fsm_state = state;
    assign unused_bits = &{1'b0, bus.addr[1:0], bus.wdata[31:16]};

    // Read mux reflects register state as of the accept edge.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.addr[3:2])
            2'd1:    rd_mux = {27'd0, ie, overflow, empty, full, busy};
            2'd2:    rd_mux = {16'd0, baud_div};
            default: rd_mux = 32'd0;
        endcase
    end

    // Bus response: one-cycle ack after accept, read data only alongside ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack   <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            bus.ack   <= accept;
            bus.rdata <= (accept && !bus.we) ? rd_mux : 32'd0;
        end
    end

    // FIFO storage; a push into a full FIFO is allowed only when the head pops the same edge.
    always_ff @(posedge clk) begin
        if (push && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers, one bit wider than the index to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && (!full || pop)) wr_ptr <= wr_ptr + 1'b1;
            if (pop)                    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Control registers: sticky overflow, interrupt enable, bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            ie       <= 1'b0;
            baud_div <= BAUD_RESET;
        end else begin
            if (push && full && !pop)          overflow <= 1'b1;
            else if (wr_status && bus.wdata[3]) overflow <= 1'b0;
            if (wr_status) ie       <= bus.wdata[4];
            if (wr_baud)   baud_div <= bus.wdata[15:0];
        end
    end

    // Level interrupt registered from current state, so it lags its cause by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= overflow | (ie & empty & ~busy);
    end

    // Transmit FSM; tx is registered and each bit is held for eff_div cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= 8'd0;
            bit_idx <= 3'd0;
            bit_cnt <= 16'd0;
            eff_div <= 16'd2;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr[AW-1:0]];
                        eff_div <= next_div;
                        bit_cnt <= next_div - 16'd1;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= eff_div - 16'd1;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= eff_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt == 16'd0) state   <= IDLE;
                    else                  bit_cnt <= bit_cnt - 16'd1;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
